// File: rtl/spi_job_loader_pkg.sv
// Shared definitions for the SPI job loader: job frame layout and FSM state encoding.
package spi_job_loader_pkg;

  localparam int SHA_STATE_WIDTH    = 256;
  localparam int MESSAGE_HEAD_WIDTH = 96;
  localparam int DIFFICULTY_WIDTH   = 8;
  localparam int JOB_FRAME_WIDTH    = SHA_STATE_WIDTH + MESSAGE_HEAD_WIDTH + DIFFICULTY_WIDTH;

  // Field order matches the on-wire order (sha_state is sent first, MSB first).
  typedef struct packed {
    logic [SHA_STATE_WIDTH-1:0]    sha_state;
    logic [MESSAGE_HEAD_WIDTH-1:0] message_head;
    logic [DIFFICULTY_WIDTH-1:0]   difficulty;
  } job_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_CHECK = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus single-cycle rise/fall pulses
// derived from the synchronized value.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_job_loader.sv
// SPI mode-0 slave that collects a fixed-length job frame and commits it atomically
// to job_out when chip select rises after exactly JOB_WIDTH bits.
module spi_job_loader
  import spi_job_loader_pkg::*;
#(
  parameter int JOB_WIDTH = JOB_FRAME_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 sck_in,
  input  logic                 sdi_in,
  input  logic                 cs_n_in,
  output logic [JOB_WIDTH-1:0] job_out,
  output logic                 job_valid_out,
  output logic [7:0]           job_id_out,
  output logic                 busy_out,
  output logic                 error_out
);

  localparam int CNT_W = $clog2(JOB_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(JOB_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(JOB_WIDTH + 1);

  logic sck_rise;
  logic sck_level_unused;
  logic sck_fall_unused;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;

  sync_edge_detect #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk_in),
    .rst   (reset_in),
    .raw   (sck_in),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall_unused)
  );

  sync_edge_detect #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk_in),
    .rst   (reset_in),
    .raw   (cs_n_in),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  logic sdi_meta;
  logic sdi_sync;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_meta <= sdi_in;
      sdi_sync <= sdi_meta;
    end
  end

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [JOB_WIDTH-1:0] shreg;
  logic [1:0]           settle;
  logic                 armed;
  logic                 shift_en;

  // A sck rise coinciding with the cs rise belongs to no frame and is dropped.
  assign shift_en = (state == ST_SHIFT) && sck_rise && !cs_rise;

  always_ff @(posedge clk_in) begin
    if (shift_en) begin
      shreg <= {shreg[JOB_WIDTH-2:0], sdi_sync};
    end
  end

  // The cs synchronizer holds its reset value for two cycles, so cs is only
  // trusted once it has flushed; a frame may start only after cs is seen high,
  // which discards the tail of any frame interrupted by reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      job_out       <= '0;
      job_valid_out <= 1'b0;
      job_id_out    <= 8'd0;
      busy_out      <= 1'b0;
      error_out     <= 1'b0;
      settle        <= 2'd0;
      armed         <= 1'b0;
    end else begin
      job_valid_out <= 1'b0;
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end else if (cs_level) begin
        armed <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall && armed) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            error_out <= 1'b0;
            busy_out  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            // Commit is registered on entry to CHECK so the valid pulse
            // coincides with the single CHECK cycle.
            state <= ST_CHECK;
            if (bit_cnt == CNT_FULL) begin
              job_out       <= shreg;
              job_valid_out <= 1'b1;
              job_id_out    <= job_id_out + 8'd1;
            end else begin
              error_out <= 1'b1;
            end
          end else if (sck_rise && bit_cnt != CNT_SAT) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_job_loader.md
SPI_JOB_LOADER -- requirements
Module: spi_job_loader

Interface
REQ-001 SHALL have parameter JOB_WIDTH, default 360, meaning job frame bits (256 sha_state + 96 message_head + 8 difficulty).
REQ-002 SHALL have port clk_in, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_in, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port sck_in, input, 1, SPI(0) clock, asynchronous to clk_in.
REQ-005 SHALL have port sdi_in, input, 1, SPI(0) data, MSB first.
REQ-006 SHALL have port cs_n_in, input, 1, SPI(0) chip select, active-low, asynchronous.
REQ-007 SHALL have port job_out, output, JOB_WIDTH, last committed job {sha_state, message_head, difficulty}.
REQ-008 SHALL have port job_valid_out, output, 1, one-cycle pulse on each commit.
REQ-009 SHALL have port job_id_out, output, 8, commit counter.
REQ-010 SHALL have port busy_out, output, 1, high while a frame is in progress.
REQ-011 SHALL have port error_out, output, 1, last frame had a bad length.

Function
REQ-012 SHALL pass sck_in, sdi_in and cs_n_in each through a 2-flop synchronizer before use; clk_in is at least 4x sck frequency.
REQ-013 SHALL implement states IDLE, SHIFT and CHECK.
REQ-014 IDLE->SHIFT on synchronized cs_n falling edge: clear bit count and error_out, set busy_out.
REQ-015 In SHIFT, each synchronized sck rising edge SHALL shift sdi into the LSB of the shift register and increment the bit count.
REQ-016 The bit count SHALL saturate at JOB_WIDTH+1 and SHALL NOT wrap.
REQ-017 A sck edge in the same cycle as the cs_n rising edge SHALL be ignored.
REQ-018 SHIFT->CHECK on synchronized cs_n rising edge.
REQ-019 CHECK SHALL last exactly one cycle, then go to IDLE with busy_out low.
REQ-020 In CHECK with count == JOB_WIDTH: job_out <= shift register, job_valid_out high for that cycle, job_id_out increments (wraps 255->0), error_out stays 0.
REQ-021 In CHECK with count != JOB_WIDTH (short, long or zero bits): job_out and job_id_out unchanged, no valid pulse, error_out <= 1.
REQ-022 error_out SHALL hold until the next frame start or reset.
REQ-023 job_out SHALL change only in CHECK, so the downstream hash pool sees stable parameters between commits.
REQ-024 A sck edge while in IDLE SHALL be ignored.
REQ-025 Latency: job_valid_out SHALL assert 1 cycle after the synchronized cs_n rise, i.e. 3 clk_in cycles after the raw cs_n_in rise.

Reset
REQ-026 reset_in SHALL set state IDLE, job_out 0, job_valid_out 0, job_id_out 0, busy_out 0, error_out 0, bit count 0, and synchronizer flops to idle values (cs_n 1, sck 0).
REQ-027 Reset mid-frame SHALL discard the partial frame.
REQ-028 After reset, if cs_n is still low, the remainder of that frame SHALL be ignored until cs_n is seen high and then falls again.

Structure
REQ-029 A shared package SHALL hold the JOB_WIDTH components (SHA_STATE_WIDTH 256, MESSAGE_HEAD_WIDTH 96, DIFFICULTY_WIDTH 8) and the state encoding.
REQ-030 The block SHALL use one sub-module, sync_edge_detect: a 2-flop synchronizer with rise/fall pulse outputs, instanced for sck and cs_n.

Verification
REQ-031 Send a 360-bit frame with sha_state = 0x00..01, message_head = 0xAB..AB, difficulty = 0x05 -> job_out equals that frame, one valid pulse, job_id_out 1, error_out 0.
REQ-032 Send a 359-bit frame, then a 361-bit frame -> both give error_out 1, job_out unchanged, no valid pulse, job_id_out unchanged.
REQ-033 Send 256 good frames from reset -> job_id_out wraps to 0, with 256 valid pulses.
REQ-034 Assert reset_in after 100 bits, release it with cs_n still low, clock 260 more bits, raise cs_n -> no commit and error_out 0; the next full frame commits normally.
REQ-035 Align the 360th sck rise with the cs_n rise -> that edge is dropped, count is 359, error_out 1.
REQ-036 Toggle sck with cs_n high -> no state change and busy_out stays 0.
